v_fifo_ring: RTL and testbench

Parametrised multi-vector ring FIFO for inter-layer buffering in the MLP pipeline, sitting between producers (vwb_gemm, v_leakyrelu) and their consumers. It generalises the single-vector v_fifo in four ways:
- Depth greater than 1.
- Element-granular width conversion between write and read chunks.
- Explicit ready and valid flags.
- Occupancy count and a vector-available flag.

---
 rtl/v_fifo_pkg.sv | 25 ++
 rtl/v_fifo_ring_ptr.sv | 49 ++++
 rtl/v_fifo_ring.sv | 145 ++++++++++++++
 tb/tb_v_fifo_ring.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : v_fifo_pkg                                                       |
// | Purpose : width helpers and parameter legality check shared by FIFOs       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package v_fifo_pkg;

  // A one-slot ring still needs a 1-bit pointer to keep port widths legal.
  function automatic int ptr_w(input int cap);
    return (cap > 1) ? $clog2(cap) : 1;
  endfunction

  function automatic int cnt_w(input int cap);
    return $clog2(cap + 1);
  endfunction

  function automatic bit params_ok(input int vec_el, input int el_wr,
                                   input int el_rd, input int depth);
    return (depth >= 1) && (el_wr >= 1) && (el_rd >= 1) &&
           (vec_el % el_wr == 0) && (vec_el % el_rd == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/v_fifo_ring_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : v_fifo_ring_ptr                                                  |
// | Purpose : modulo-Cap ring pointer advancing by Step on inc, zeroed on clr  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module v_fifo_ring_ptr
  import v_fifo_pkg::*;
#(
  parameter int Cap  = 40,
  parameter int Step = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ptr_w(Cap)-1:0] ptr
);

  localparam int PW = ptr_w(Cap);
  localparam logic [PW:0] STEP_W = (PW + 1)'(Step);
  localparam logic [PW:0] CAP_W  = (PW + 1)'(Cap);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   sum;

  // Cap is a multiple of Step, so a step lands exactly on Cap at the wrap.
  always_comb begin
    sum   = {1'b0, ptr_q} + STEP_W;
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (sum >= CAP_W) ? '0 : sum[PW-1:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/v_fifo_ring.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : v_fifo_ring                                                      |
// | Purpose : multi-vector ring FIFO with write/read chunk width conversion.   |
// |           Define V_FIFO_RING_ERR_EN for sticky overflow/underflow flags.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module v_fifo_ring
  import v_fifo_pkg::*;
#(
  parameter int VecElements      = 20,
  parameter int ElementsPerWrite = 1,
  parameter int ElementsPerRead  = 20,
  parameter int NBits            = 12,
  parameter int Depth            = 2
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   ptr_rst,
  input  logic                                   wr_en,
  input  logic [ElementsPerWrite*NBits-1:0]      wr_data,
  output logic                                   wr_ready,
  input  logic                                   rd_en,
  output logic [ElementsPerRead*NBits-1:0]       rd_data,
  output logic                                   rd_valid,
  output logic                                   rd_ready,
  output logic                                   vec_avail,
  output logic [cnt_w(Depth*VecElements)-1:0]    count,
  output logic                                   overflow,
  output logic                                   underflow
);

  localparam int Cap = Depth * VecElements;
  localparam int PW  = ptr_w(Cap);
  localparam int CW  = cnt_w(Cap);
  localparam logic [CW-1:0] EPW_C = CW'(ElementsPerWrite);
  localparam logic [CW-1:0] EPR_C = CW'(ElementsPerRead);
  localparam logic [CW-1:0] VEC_C = CW'(VecElements);

  generate
    if (!params_ok(VecElements, ElementsPerWrite, ElementsPerRead, Depth)) begin : g_param_check
      $error("v_fifo_ring: chunk sizes must divide VecElements and Depth must be >= 1");
    end
  endgenerate

  logic [NBits-1:0]                 mem_q [Cap];
  logic [PW-1:0]                    wr_ptr, rd_ptr;
  logic [CW-1:0]                    count_q, count_d;
  logic [ElementsPerRead*NBits-1:0] rd_data_q, rd_data_d;
  logic                             rd_valid_q, rd_valid_d;
  logic                             wr_acc, rd_acc;

  assign wr_ready  = (int'(count_q) + ElementsPerWrite) <= Cap;
  assign rd_ready  = count_q >= EPR_C;
  assign vec_avail = count_q >= VEC_C;

  // A flush takes priority and drops any same-cycle transfer.
  assign wr_acc = wr_en && wr_ready && !ptr_rst;
  assign rd_acc = rd_en && rd_ready && !ptr_rst;

  v_fifo_ring_ptr #(.Cap(Cap), .Step(ElementsPerWrite)) u_wr_ptr (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (ptr_rst),
    .inc    (wr_acc),
    .ptr    (wr_ptr)
  );

  v_fifo_ring_ptr #(.Cap(Cap), .Step(ElementsPerRead)) u_rd_ptr (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (ptr_rst),
    .inc    (rd_acc),
    .ptr    (rd_ptr)
  );

  always_ff @(posedge clk_in) begin
    if (wr_acc) begin
      for (int i = 0; i < ElementsPerWrite; i++) begin
        mem_q[wr_ptr + PW'(i)] <= wr_data[i*NBits +: NBits];
      end
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    count_d    = count_q;
    if (rd_acc) begin
      for (int i = 0; i < ElementsPerRead; i++) begin
        rd_data_d[i*NBits +: NBits] = mem_q[rd_ptr + PW'(i)];
      end
    end
    if (ptr_rst) begin
      count_d = '0;
    end else begin
      count_d = count_q + (wr_acc ? EPW_C : '0) - (rd_acc ? EPR_C : '0);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign count    = count_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef V_FIFO_RING_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky until rst_in; a flush does not clear them.
  always_comb begin
    overflow_d  = overflow_q  | (wr_en & ~wr_ready);
    underflow_d = underflow_q | (rd_en & ~rd_ready);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_v_fifo_ring.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_v_fifo_ring                                                   |
// | Purpose : directed bench for v_fifo_ring, default and 20-to-1 configs      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_v_fifo_ring;

`ifdef V_FIFO_RING_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DUT A: defaults (write 1, read 20, capacity 40)
  logic         a_ptr_rst, a_wr_en, a_rd_en;
  logic [11:0]  a_wr_data;
  logic         a_wr_ready, a_rd_valid, a_rd_ready, a_vec_avail, a_ovf, a_unf;
  logic [239:0] a_rd_data;
  logic [5:0]   a_count;

  // DUT B: write 20, read 1, capacity 20
  logic         b_ptr_rst, b_wr_en, b_rd_en;
  logic [239:0] b_wr_data;
  logic         b_wr_ready, b_rd_valid, b_rd_ready, b_vec_avail, b_ovf, b_unf;
  logic [11:0]  b_rd_data;
  logic [4:0]   b_count;

  v_fifo_ring dut_a (
    .clk_in    (clk),
    .rst_in    (rst),
    .ptr_rst   (a_ptr_rst),
    .wr_en     (a_wr_en),
    .wr_data   (a_wr_data),
    .wr_ready  (a_wr_ready),
    .rd_en     (a_rd_en),
    .rd_data   (a_rd_data),
    .rd_valid  (a_rd_valid),
    .rd_ready  (a_rd_ready),
    .vec_avail (a_vec_avail),
    .count     (a_count),
    .overflow  (a_ovf),
    .underflow (a_unf)
  );

  v_fifo_ring #(.VecElements(20), .ElementsPerWrite(20), .ElementsPerRead(1),
                .NBits(12), .Depth(1)) dut_b (
    .clk_in    (clk),
    .rst_in    (rst),
    .ptr_rst   (b_ptr_rst),
    .wr_en     (b_wr_en),
    .wr_data   (b_wr_data),
    .wr_ready  (b_wr_ready),
    .rd_en     (b_rd_en),
    .rd_data   (b_rd_data),
    .rd_valid  (b_rd_valid),
    .rd_ready  (b_rd_ready),
    .vec_avail (b_vec_avail),
    .count     (b_count),
    .overflow  (b_ovf),
    .underflow (b_unf)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [239:0] seq(input int base);
    logic [239:0] v;
    for (int i = 0; i < 20; i++) v[i*12 +: 12] = 12'(base + i);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model for DUT A: an element queue plus the last returned chunk.
  logic [11:0]  q[$];
  logic [239:0] m_rd_data = '0;
  bit           m_valid   = 1'b0;
  bit           m_ovf     = 1'b0;
  bit           m_unf     = 1'b0;
  bit           m_wr_ok, m_rd_ok;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_rd_data = '0;
      m_valid   = 1'b0;
      m_ovf     = 1'b0;
      m_unf     = 1'b0;
    end else begin
      m_wr_ok = (q.size() + 1) <= 40;
      m_rd_ok = q.size() >= 20;
      if (ERR_EN && a_wr_en && !m_wr_ok) m_ovf = 1'b1;
      if (ERR_EN && a_rd_en && !m_rd_ok) m_unf = 1'b1;
      if (a_ptr_rst) begin
        q.delete();
        m_valid = 1'b0;
      end else begin
        m_valid = a_rd_en && m_rd_ok;
        if (m_valid) begin
          for (int i = 0; i < 20; i++) m_rd_data[i*12 +: 12] = q.pop_front();
        end
        if (a_wr_en && m_wr_ok) q.push_back(a_wr_data);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count",     a_count,     q.size());
      chk("m_wr_ready",  a_wr_ready,  (q.size() + 1) <= 40);
      chk("m_rd_ready",  a_rd_ready,  q.size() >= 20);
      chk("m_vec_avail", a_vec_avail, q.size() >= 20);
      chk("m_rd_valid",  a_rd_valid,  m_valid);
      chk("m_rd_data",   a_rd_data,   m_rd_data);
      chk("m_overflow",  a_ovf,       m_ovf);
      chk("m_underflow", a_unf,       m_unf);
    end
  end

  task automatic a_write(input int base, input int n);
    a_wr_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      a_wr_data = 12'(base + k);
      step();
    end
    a_wr_en = 1'b0;
  endtask

  task automatic a_read();
    a_rd_en = 1'b1;
    step();
    a_rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_ptr_rst = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_data = '0;
    b_ptr_rst = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_data = '0;
    step();
    chk_en = 1'b1;
    step();
    chk("reset_count",    a_count,    6'd0);
    chk("reset_wr_ready", a_wr_ready, 1'b1);
    chk("reset_rd_ready", a_rd_ready, 1'b0);
    chk("reset_vec",      a_vec_avail, 1'b0);
    chk("reset_rd_data",  a_rd_data,  240'd0);
    rst = 1'b0;

    // Single-element writes, one vector read
    a_write(0, 20);
    chk("fill20_count", a_count,     6'd20);
    chk("fill20_vec",   a_vec_avail, 1'b1);
    chk("fill20_rdy",   a_rd_ready,  1'b1);
    a_read();
    chk("read0_valid", a_rd_valid, 1'b1);
    chk("read0_data",  a_rd_data,  seq(0));
    chk("read0_count", a_count,    6'd0);
    step();
    chk("read0_valid_drop", a_rd_valid, 1'b0);

    // Full FIFO refuses a write
    a_write(200, 40);
    chk("full_wr_ready", a_wr_ready, 1'b0);
    a_write(999, 1);
    chk("full_count",    a_count, 6'd40);
    chk("full_overflow", a_ovf,   ERR_EN);

    // Reset mid-operation with a pending read
    rst = 1'b1; a_rd_en = 1'b1;
    step();
    rst = 1'b0; a_rd_en = 1'b0;
    chk("rst_count",    a_count,    6'd0);
    chk("rst_valid",    a_rd_valid, 1'b0);
    chk("rst_overflow", a_ovf,      1'b0);
    chk("rst_rd_data",  a_rd_data,  240'd0);

    // Wrap-around
    a_write(0, 40);
    a_read();
    chk("wrap_r1", a_rd_data, seq(0));
    a_write(100, 20);
    a_rd_en = 1'b1;
    step();
    chk("wrap_r2", a_rd_data, seq(20));
    step();
    chk("wrap_r3", a_rd_data, seq(100));
    a_rd_en = 1'b0;
    chk("wrap_count",  a_count,      6'd0);
    chk("wrap_wr_ptr", dut_a.wr_ptr, 6'd20);
    chk("wrap_rd_ptr", dut_a.rd_ptr, 6'd20);

    // Simultaneous read and write at count 20
    a_write(50, 20);
    a_wr_en = 1'b1; a_wr_data = 12'd7; a_rd_en = 1'b1;
    step();
    a_wr_en = 1'b0; a_rd_en = 1'b0;
    chk("simul_data",  a_rd_data, seq(50));
    chk("simul_count", a_count,   6'd1);
    a_write(8, 19);
    a_read();
    chk("simul_next", a_rd_data, seq(7));

    // Read while empty is refused
    a_read();
    chk("empty_rd_valid",  a_rd_valid, 1'b0);
    chk("empty_underflow", a_unf,      ERR_EN);
    chk("empty_rd_hold",   a_rd_data,  seq(7));

    // Flush overrides a same-cycle write
    a_write(1, 7);
    chk("pre_flush_count", a_count, 6'd7);
    a_ptr_rst = 1'b1; a_wr_en = 1'b1; a_wr_data = 12'd99;
    step();
    a_ptr_rst = 1'b0; a_wr_en = 1'b0;
    chk("flush_count",    a_count,    6'd0);
    chk("flush_rd_ready", a_rd_ready, 1'b0);
    chk("flush_underflow_kept", a_unf, ERR_EN);
    a_write(5, 20);
    a_read();
    chk("flush_readback", a_rd_data, seq(5));

    // DUT B: one 20-element write, 20 single-element reads, one refused read
    chk_en = 1'b0;
    b_wr_data = seq(0);
    b_wr_en = 1'b1;
    step();
    b_wr_en = 1'b0;
    chk("b_count",    b_count,    5'd20);
    chk("b_wr_ready", b_wr_ready, 1'b0);
    chk("b_rd_ready", b_rd_ready, 1'b1);
    chk("b_vec",      b_vec_avail, 1'b1);
    b_rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("b_rd_valid", b_rd_valid, 1'b1);
      chk("b_rd_data",  b_rd_data,  12'(k));
    end
    step();
    b_rd_en = 1'b0;
    chk("b_21_valid",     b_rd_valid, 1'b0);
    chk("b_21_underflow", b_unf,      ERR_EN);
    chk("b_21_hold",      b_rd_data,  12'd19);
    chk("b_21_count",     b_count,    5'd0);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
